// File: rtl/lsu_bus_responder.sv
// LSU bus responder: range-checks one dword load/store from exec_mem, runs it on the
// data memory bus and hands back a single-cycle response. One access in flight at most.

module lsu_bus_responder_chk (
  input  logic clk,
  input  logic rst,
  input  logic mem_rvalid,
  input  logic in_wait,
  input  logic orphan
);

  // A completion is only legal while waiting on our own access or draining an orphan.
  a_no_stray_rvalid : assert property (@(posedge clk) disable iff (!rst)
    !(mem_rvalid && !in_wait && !orphan));

endmodule

module lsu_bus_responder #(
  parameter int          ADDR_W         = 61,
  parameter int          XLEN           = 64,
  parameter logic [63:0] RAM_BASE_LINE  = 64'h0,
  parameter logic [63:0] RAM_LINES      = 64'h4000,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lsu_prev_stalled,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_do_load,
  input  logic                lsu_do_store,
  input  logic [XLEN-1:0]     lsu_store_data,
  input  logic [XLEN/8-1:0]   lsu_store_mask,
  output logic                lsu_stall_next,
  output logic [XLEN-1:0]     lsu_load_data,
  output logic                lsu_access_fault,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_wmask,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic                mem_err
);

  localparam int MW = XLEN / 8;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [ADDR_W:0] BASE_EXT  = (ADDR_W+1)'(RAM_BASE_LINE);
  localparam logic [ADDR_W:0] LINES_EXT = (ADDR_W+1)'(RAM_LINES);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic              stall_r, stall_s;
  logic [XLEN-1:0]   load_data_r, load_data_s;
  logic              fault_r, fault_s;
  logic              mem_req_r, mem_req_s;
  logic              mem_we_r, mem_we_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [XLEN-1:0]   mem_wdata_r, mem_wdata_s;
  logic [MW-1:0]     mem_wmask_r, mem_wmask_s;
  logic              orphan_r, orphan_s;
  logic [TW-1:0]     timer_r, timer_s;

  logic [ADDR_W:0]   offset_s;
  logic              in_range_s;
  logic              req_valid_s;

  // Offset from the window base at one extra bit: the MSB flags addr < base, and the
  // upper bound never wraps because the offset is strictly below 2^ADDR_W.
  always_comb begin
    offset_s    = {1'b0, lsu_addr} - BASE_EXT;
    in_range_s  = !offset_s[ADDR_W] && (offset_s < LINES_EXT);
    req_valid_s = !lsu_prev_stalled && (lsu_do_load || lsu_do_store);
  end

  // Next-state and next-output computation for the responder FSM.
  always_comb begin
    state_s     = state_r;
    load_data_s = load_data_r;
    fault_s     = fault_r;
    mem_we_s    = mem_we_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    mem_wmask_s = mem_wmask_r;
    timer_s     = timer_r;
    if (orphan_r && mem_rvalid) begin
      orphan_s = 1'b0;
    end else begin
      orphan_s = orphan_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (req_valid_s) begin
          mem_addr_s  = lsu_addr;
          mem_we_s    = lsu_do_store;
          mem_wdata_s = lsu_store_data;
          mem_wmask_s = lsu_store_mask;
          if (in_range_s) begin
            state_s = ST_REQ;
          end else begin
            state_s = ST_RESP;
            fault_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_req_r && mem_ready) begin
          state_s = ST_WAIT;
          timer_s = {TW{1'b0}};
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        timer_s = timer_r + 1'b1;
        // A completion in the timeout cycle still counts as a normal response.
        if (mem_rvalid) begin
          state_s = ST_RESP;
          fault_s = mem_err;
          if (!mem_we_r) begin
            load_data_s = mem_rdata;
          end else begin
            load_data_s = load_data_r;
          end
        end else if (timer_r == TIMER_LAST) begin
          state_s  = ST_RESP;
          fault_s  = 1'b1;
          orphan_s = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
        fault_s = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        fault_s = 1'b0;
      end
    endcase

    // The bus request is withheld while a timed-out access may still complete.
    mem_req_s = (state_s == ST_REQ) && !orphan_s;
    stall_s   = (state_s != ST_RESP);
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      stall_r     <= 1'b1;
      load_data_r <= {XLEN{1'b0}};
      fault_r     <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {XLEN{1'b0}};
      mem_wmask_r <= {MW{1'b0}};
      orphan_r    <= 1'b0;
      timer_r     <= {TW{1'b0}};
    end else begin
      state_r     <= state_s;
      stall_r     <= stall_s;
      load_data_r <= load_data_s;
      fault_r     <= fault_s;
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      mem_wmask_r <= mem_wmask_s;
      orphan_r    <= orphan_s;
      timer_r     <= timer_s;
    end
  end

  assign lsu_stall_next   = stall_r;
  assign lsu_load_data    = load_data_r;
  assign lsu_access_fault = fault_r;
  assign mem_req          = mem_req_r;
  assign mem_we           = mem_we_r;
  assign mem_addr         = mem_addr_r;
  assign mem_wdata        = mem_wdata_r;
  assign mem_wmask        = mem_wmask_r;

  lsu_bus_responder_chk u_chk (
    .clk        (clk),
    .rst        (rst),
    .mem_rvalid (mem_rvalid),
    .in_wait    (state_r == ST_WAIT),
    .orphan     (orphan_r)
  );

endmodule

// File: tb/tb_lsu_bus_responder.sv
// Directed bench for lsu_bus_responder: loads, stores, range faults, bus errors,
// timeout with orphan drain, reset mid-access and back-to-back requests.

module tb_lsu_bus_responder;

  localparam int          ADDR_W = 61;
  localparam int          XLEN   = 64;
  localparam logic [60:0] BASE   = 61'h100;
  localparam logic [60:0] LINES  = 61'h4000;

  logic              clk;
  logic              rst;
  logic              lsu_prev_stalled;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_do_load;
  logic              lsu_do_store;
  logic [XLEN-1:0]   lsu_store_data;
  logic [7:0]        lsu_store_mask;
  logic              lsu_stall_next;
  logic [XLEN-1:0]   lsu_load_data;
  logic              lsu_access_fault;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [7:0]        mem_wmask;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_err;

  int total;
  int bad;

  lsu_bus_responder #(
    .ADDR_W         (ADDR_W),
    .XLEN           (XLEN),
    .RAM_BASE_LINE  (64'h100),
    .RAM_LINES      (64'h4000),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .lsu_prev_stalled (lsu_prev_stalled),
    .lsu_addr         (lsu_addr),
    .lsu_do_load      (lsu_do_load),
    .lsu_do_store     (lsu_do_store),
    .lsu_store_data   (lsu_store_data),
    .lsu_store_mask   (lsu_store_mask),
    .lsu_stall_next   (lsu_stall_next),
    .lsu_load_data    (lsu_load_data),
    .lsu_access_fault (lsu_access_fault),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_wmask        (mem_wmask),
    .mem_ready        (mem_ready),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata),
    .mem_err          (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single cycle; on return the accept edge has passed.
  task automatic present(input logic [60:0] addr, input logic store,
                         input logic [63:0] data, input logic [7:0] mask);
    lsu_prev_stalled = 1'b0;
    lsu_addr         = addr;
    lsu_do_load      = !store;
    lsu_do_store     = store;
    lsu_store_data   = data;
    lsu_store_mask   = mask;
    tick();
    lsu_prev_stalled = 1'b1;
    lsu_do_load      = 1'b0;
    lsu_do_store     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0;
    lsu_prev_stalled = 1'b1;
    lsu_addr = 61'h0;
    lsu_do_load = 1'b0;
    lsu_do_store = 1'b0;
    lsu_store_data = 64'h0;
    lsu_store_mask = 8'h00;
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 64'h0;
    mem_err = 1'b0;

    tick();
    tick();
    chk("rst_stall", {63'h0, lsu_stall_next}, 64'h1);
    chk("rst_req", {63'h0, mem_req}, 64'h0);
    chk("rst_fault", {63'h0, lsu_access_fault}, 64'h0);
    chk("rst_ldata", lsu_load_data, 64'h0);
    chk("rst_addr", {3'h0, mem_addr}, 64'h0);
    rst = 1'b1;
    tick();

    // Load in range: ready in N+1, rvalid in N+2, response in N+3.
    present(BASE + 61'd5, 1'b0, 64'h0, 8'h00);
    chk("ld_req", {63'h0, mem_req}, 64'h1);
    chk("ld_addr", {3'h0, mem_addr}, {3'h0, BASE + 61'd5});
    chk("ld_we", {63'h0, mem_we}, 64'h0);
    chk("ld_stall_n1", {63'h0, lsu_stall_next}, 64'h1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("ld_req_drop", {63'h0, mem_req}, 64'h0);
    chk("ld_stall_n2", {63'h0, lsu_stall_next}, 64'h1);
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h1122334455667788;
    tick();
    mem_rvalid = 1'b0;
    chk("ld_stall_n3", {63'h0, lsu_stall_next}, 64'h0);
    chk("ld_data", lsu_load_data, 64'h1122334455667788);
    chk("ld_fault", {63'h0, lsu_access_fault}, 64'h0);
    tick();
    chk("ld_stall_n4", {63'h0, lsu_stall_next}, 64'h1);

    // Store with mem_ready low for three cycles: request stable for four.
    present(BASE + 61'h10, 1'b1, 64'hDEADBEEF_DEADBEEF, 8'h0F);
    for (int i = 0; i < 4; i++) begin
      chk("st_req", {63'h0, mem_req}, 64'h1);
      chk("st_we", {63'h0, mem_we}, 64'h1);
      chk("st_addr", {3'h0, mem_addr}, {3'h0, BASE + 61'h10});
      chk("st_wdata", mem_wdata, 64'hDEADBEEF_DEADBEEF);
      chk("st_wmask", {56'h0, mem_wmask}, 64'h0F);
      chk("st_stall_hold", {63'h0, lsu_stall_next}, 64'h1);
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    mem_ready = 1'b0;
    chk("st_req_drop", {63'h0, mem_req}, 64'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h5555AAAA5555AAAA;
    tick();
    mem_rvalid = 1'b0;
    chk("st_resp", {63'h0, lsu_stall_next}, 64'h0);
    chk("st_fault", {63'h0, lsu_access_fault}, 64'h0);
    chk("st_ldata_kept", lsu_load_data, 64'h1122334455667788);
    tick();
    chk("st_single_a", {63'h0, lsu_stall_next}, 64'h1);
    tick();
    chk("st_single_b", {63'h0, lsu_stall_next}, 64'h1);

    // Out of range just past the end, then just below the base.
    present(BASE + LINES, 1'b0, 64'h0, 8'h00);
    chk("oor_hi_stall", {63'h0, lsu_stall_next}, 64'h0);
    chk("oor_hi_fault", {63'h0, lsu_access_fault}, 64'h1);
    chk("oor_hi_req", {63'h0, mem_req}, 64'h0);
    tick();
    chk("oor_hi_idle", {63'h0, lsu_stall_next}, 64'h1);
    chk("oor_hi_req2", {63'h0, mem_req}, 64'h0);
    present(BASE - 61'd1, 1'b0, 64'h0, 8'h00);
    chk("oor_lo_stall", {63'h0, lsu_stall_next}, 64'h0);
    chk("oor_lo_fault", {63'h0, lsu_access_fault}, 64'h1);
    chk("oor_lo_req", {63'h0, mem_req}, 64'h0);
    tick();
    chk("oor_lo_req2", {63'h0, mem_req}, 64'h0);

    // Bus error on a load.
    present(BASE + 61'd1, 1'b0, 64'h0, 8'h00);
    mem_ready = 1'b1;
    tick();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_err    = 1'b1;
    mem_rdata  = 64'h0;
    tick();
    mem_rvalid = 1'b0;
    mem_err    = 1'b0;
    chk("err_stall", {63'h0, lsu_stall_next}, 64'h0);
    chk("err_fault", {63'h0, lsu_access_fault}, 64'h1);
    tick();
    chk("err_one_cycle", {63'h0, lsu_stall_next}, 64'h1);

    // Timeout after 16 WAIT cycles, then orphan drain before the next request issues.
    present(BASE + 61'd2, 1'b0, 64'h0, 8'h00);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("to_wait_stall", {63'h0, lsu_stall_next}, 64'h1);
      tick();
    end
    chk("to_resp", {63'h0, lsu_stall_next}, 64'h0);
    chk("to_fault", {63'h0, lsu_access_fault}, 64'h1);
    tick();
    present(BASE + 61'd3, 1'b0, 64'h0, 8'h00);
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("orph_req_held", {63'h0, mem_req}, 64'h0);
      tick();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hBAD;
    chk("orph_req_held_rv", {63'h0, mem_req}, 64'h0);
    tick();
    mem_rvalid = 1'b0;
    chk("orph_req_issued", {63'h0, mem_req}, 64'h1);
    chk("orph_addr", {3'h0, mem_addr}, {3'h0, BASE + 61'd3});
    chk("orph_no_resp", {63'h0, lsu_stall_next}, 64'h1);
    tick();
    mem_ready = 1'b0;
    chk("orph_req_drop", {63'h0, mem_req}, 64'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hCAFEF00D12345678;
    tick();
    mem_rvalid = 1'b0;
    chk("orph_resp", {63'h0, lsu_stall_next}, 64'h0);
    chk("orph_data", lsu_load_data, 64'hCAFEF00D12345678);
    chk("orph_fault", {63'h0, lsu_access_fault}, 64'h0);
    tick();

    // Reset while waiting on the bus.
    present(BASE + 61'd4, 1'b0, 64'h0, 8'h00);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("rw_in_wait", {63'h0, mem_req}, 64'h0);
    rst = 1'b0;
    tick();
    chk("rw_stall", {63'h0, lsu_stall_next}, 64'h1);
    chk("rw_req", {63'h0, mem_req}, 64'h0);
    chk("rw_fault", {63'h0, lsu_access_fault}, 64'h0);
    chk("rw_ldata", lsu_load_data, 64'h0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rw_no_pulse", {63'h0, lsu_stall_next}, 64'h1);
    end

    // Back-to-back: load, then store presented in the cycle after its response.
    mem_ready = 1'b1;
    present(BASE + 61'd6, 1'b0, 64'h0, 8'h00);
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h0102030405060708;
    tick();
    mem_rvalid = 1'b0;
    chk("b2b_ld_resp", {63'h0, lsu_stall_next}, 64'h0);
    chk("b2b_ld_data", lsu_load_data, 64'h0102030405060708);
    tick();
    present(BASE + 61'd7, 1'b1, 64'hAAAA5555AAAA5555, 8'hFF);
    chk("b2b_st_req", {63'h0, mem_req}, 64'h1);
    chk("b2b_st_we", {63'h0, mem_we}, 64'h1);
    chk("b2b_st_addr", {3'h0, mem_addr}, {3'h0, BASE + 61'd7});
    chk("b2b_st_wdata", mem_wdata, 64'hAAAA5555AAAA5555);
    tick();
    mem_ready = 1'b0;
    chk("b2b_st_req_drop", {63'h0, mem_req}, 64'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h0;
    tick();
    mem_rvalid = 1'b0;
    chk("b2b_st_resp", {63'h0, lsu_stall_next}, 64'h0);
    chk("b2b_st_fault", {63'h0, lsu_access_fault}, 64'h0);
    chk("b2b_st_ldata", lsu_load_data, 64'h0102030405060708);
    tick();
    chk("b2b_idle", {63'h0, lsu_stall_next}, 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
